// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types and defaults for the host sequencer and its bench.
// Types only: no latency and no flow control of its own.
package tlul_pkg;

   localparam logic [2:0] PutFullData   = 3'h0;
   localparam logic [2:0] Get           = 3'h4;
   localparam logic [2:0] AccessAck     = 3'h0;
   localparam logic [2:0] AccessAckData = 3'h1;

   typedef struct packed {
      logic [4:0] rsvd;
      logic [3:0] instr_type;
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;

   typedef struct packed {
      logic [6:0] rsp_intg;
      logic [6:0] data_intg;
   } tl_d_user_t;

   localparam tl_a_user_t TL_A_USER_DEFAULT = '{
      rsvd: 5'h0, instr_type: 4'h9, cmd_intg: 7'h0, data_intg: 7'h0
   };

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      tl_a_user_t  a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      tl_d_user_t  d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   localparam tl_h2d_t TL_H2D_DEFAULT = '{
      a_valid: 1'b0, a_opcode: PutFullData, a_param: 3'h0, a_size: 2'h0,
      a_source: 8'h0, a_address: 32'h0, a_mask: 4'h0, a_data: 32'h0,
      a_user: TL_A_USER_DEFAULT, d_ready: 1'b1
   };

endpackage

// File: rtl/tlul_host_seq.sv
// TL-UL host issuing count_i strided Get/PutFullData requests; `TLUL_HOST_SEQ_SRC_CHECK_EN adds per-source tracking.
// Latency: first a_valid the cycle after start; done_o pulses one cycle after the last response.
// Backpressure: A held stable until a_ready, at most MaxOutstanding in flight; D always accepted.
module tlul_host_seq #(
   parameter int MaxOutstanding = 4,
   parameter int AddrStride     = 4,
   parameter int CntW           = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [31:0]         base_addr_i,
   input  logic [CntW-1:0]     count_i,
   input  logic                write_i,
   input  logic [31:0]         wdata_i,
   output tlul_pkg::tl_h2d_t   tl_o,
   input  tlul_pkg::tl_d2h_t   tl_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [CntW-1:0]     rsp_cnt_o,
   output logic [CntW-1:0]     err_cnt_o,
   output logic [31:0]         last_rdata_o
);
   import tlul_pkg::*;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [4:0] MaxOut  = 5'(MaxOutstanding);
   localparam logic [3:0] LastSrc = 4'(MaxOutstanding - 1);

   logic [1:0]      state_q;
   logic [CntW-1:0] issued_q, count_q, rsp_cnt_q, err_cnt_q;
   logic [31:0]     addr_q, wdata_q, last_rdata_q;
   logic            write_q;
   logic [3:0]      src_q;
   logic [4:0]      out_q, out_d;
   logic            a_vld, a_hs, d_hs, d_expected, src_free;

`ifdef TLUL_HOST_SEQ_SRC_CHECK_EN
   logic [15:0] infl_q;
   assign src_free   = ~infl_q[src_q];
   assign d_expected = (out_q != 5'd0) && (tl_i.d_source < 8'(MaxOutstanding))
                       && infl_q[tl_i.d_source[3:0]];
`else
   assign src_free   = 1'b1;
   assign d_expected = (out_q != 5'd0);
`endif

   logic unused_tl_i;
   assign unused_tl_i = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, tl_i.d_source};

   assign a_vld = (state_q == ISSUE) && (issued_q < count_q) && (out_q < MaxOut) && src_free;
   assign a_hs  = a_vld && tl_i.a_ready;
   assign d_hs  = tl_i.d_valid && tl_o.d_ready;

   // A response that is not expected never releases an in-flight slot.
   always_comb begin
      out_d = out_q;
      if (a_hs && !(d_hs && d_expected)) begin
         out_d = out_q + 5'd1;
      end else if (!a_hs && d_hs && d_expected) begin
         out_d = out_q - 5'd1;
      end
   end

   always_comb begin
      tl_o         = TL_H2D_DEFAULT;
      tl_o.a_valid = a_vld;
      if (state_q == ISSUE) begin
         tl_o.a_opcode  = write_q ? PutFullData : Get;
         tl_o.a_size    = 2'd2;
         tl_o.a_mask    = 4'hf;
         tl_o.a_address = addr_q;
         tl_o.a_data    = write_q ? wdata_q : 32'h0;
         tl_o.a_source  = {4'h0, src_q};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         issued_q     <= '0;
         count_q      <= '0;
         rsp_cnt_q    <= '0;
         err_cnt_q    <= '0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         last_rdata_q <= 32'h0;
         write_q      <= 1'b0;
         src_q        <= 4'h0;
         out_q        <= 5'd0;
      end else begin
         out_q <= out_d;
         if (a_hs) begin
            issued_q <= issued_q + CntW'(1);
            addr_q   <= addr_q + 32'(AddrStride);
            src_q    <= (src_q == LastSrc) ? 4'h0 : src_q + 4'h1;
         end
         if (d_hs) begin
            rsp_cnt_q <= rsp_cnt_q + CntW'(1);
            if ((tl_i.d_error || !d_expected) && (err_cnt_q != '1)) begin
               err_cnt_q <= err_cnt_q + CntW'(1);
            end
            if (tl_i.d_opcode == AccessAckData) begin
               last_rdata_q <= tl_i.d_data;
            end
         end
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (count_i != '0) begin
                     // Start clears override any response landing in the same cycle.
                     state_q      <= ISSUE;
                     count_q      <= count_i;
                     addr_q       <= base_addr_i;
                     write_q      <= write_i;
                     wdata_q      <= wdata_i;
                     issued_q     <= '0;
                     src_q        <= 4'h0;
                     out_q        <= 5'd0;
                     rsp_cnt_q    <= '0;
                     err_cnt_q    <= '0;
                     last_rdata_q <= 32'h0;
                  end else begin
                     state_q <= DONE;
                  end
               end
            end
            ISSUE: begin
               if (a_hs && (issued_q + CntW'(1) == count_q)) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_d == 5'd0) begin
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef TLUL_HOST_SEQ_SRC_CHECK_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         infl_q <= 16'h0;
      end else begin
         if (a_hs) begin
            infl_q[src_q] <= 1'b1;
         end
         if (d_hs && d_expected) begin
            infl_q[tl_i.d_source[3:0]] <= 1'b0;
         end
      end
   end
`endif

   assign busy_o       = (state_q == ISSUE) || (state_q == DRAIN);
   assign done_o       = (state_q == DONE);
   assign rsp_cnt_o    = rsp_cnt_q;
   assign err_cnt_o    = err_cnt_q;
   assign last_rdata_o = last_rdata_q;

endmodule

// File: tb/tb_tlul_host_seq.sv
// Bench for tlul_host_seq: scripted scenarios plus randomized sequences against a reference model.
`timescale 1ns/1ps
module tb_tlul_host_seq;
   import tlul_pkg::*;

   localparam int MAXO = 4;
   localparam int STRIDE = 4;
   localparam int CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_i = 1'b1, start_i = 1'b0, write_i = 1'b0;
   logic [31:0]   base_addr_i = '0, wdata_i = '0;
   logic [CW-1:0] count_i = '0;
   tl_h2d_t       tl_o;
   tl_d2h_t       tl_i = '0;
   logic          busy_o, done_o;
   logic [CW-1:0] rsp_cnt_o, err_cnt_o;
   logic [31:0]   last_rdata_o;

   tlul_host_seq #(.MaxOutstanding(MAXO), .AddrStride(STRIDE), .CntW(CW)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
      .count_i(count_i), .write_i(write_i), .wdata_i(wdata_i), .tl_o(tl_o), .tl_i(tl_i),
      .busy_o(busy_o), .done_o(done_o), .rsp_cnt_o(rsp_cnt_o), .err_cnt_o(err_cnt_o),
      .last_rdata_o(last_rdata_o)
   );

   int n_chk = 0, n_err = 0;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Device model and stimulus knobs
   typedef struct { logic [7:0] src; bit get; int rdy; } rsp_t;
   rsp_t dev_q[$];
   int  cyc = 0, dlat = 1, d_hold_until = 0, err_at = -1, dev_rsp_idx = 0;
   bit  dlat_rand = 0, dgap_rand = 0, err_rand = 0, noise = 0, d_from_q = 0;
   int  ar_mode = 0, ar_low = 0, ar_budget = 0;
   bit  inj_req = 0;
   logic [7:0] inj_src = '0;
   bit  start_req = 0;
   logic [31:0] req_base, req_wdata;
   logic [CW-1:0] req_count;
   logic req_write;

   int ahs_cnt = 0, done_cnt = 0, stall_cyc = 0, av_cyc = 0;
   logic [31:0] log_addr[$], log_data[$];
   logic [7:0]  log_src[$];
   logic [2:0]  log_op[$];

   // Reference model: sequence progress in terms of requests issued and in flight
   bit m_busy = 0, m_done = 0, m_write = 0;
   int m_issued = 0, m_count = 0, m_out = 0;
   logic [31:0] m_base = '0, m_wdata = '0, m_rdata = '0;
   logic [CW-1:0] m_rsp = '0, m_err = '0;
   bit [15:0] m_infl = '0;
   bit prev_stall = 0;
   tl_h2d_t prev_tl;

   always @(negedge clk) begin : monitor
      bit exp_av, ahs, dhs, d_ok, drain;
      int src;
      if (rst_i) begin
         chk("rst_tl_o_default", 32'(tl_o == TL_H2D_DEFAULT), 1);
         chk("rst_a_valid", tl_o.a_valid, 0);
         chk("rst_busy", busy_o, 0);
         chk("rst_done", done_o, 0);
         chk("rst_rsp_cnt", rsp_cnt_o, 0);
         chk("rst_err_cnt", err_cnt_o, 0);
         chk("rst_last_rdata", last_rdata_o, 0);
         m_busy = 0; m_done = 0; m_issued = 0; m_count = 0; m_out = 0;
         m_rsp = '0; m_err = '0; m_rdata = '0; m_infl = '0;
         prev_stall = 0;
         dev_q.delete();
      end else begin
         src = m_issued % MAXO;
         exp_av = m_busy && (m_issued < m_count) && (m_out < MAXO);
`ifdef TLUL_HOST_SEQ_SRC_CHECK_EN
         exp_av = exp_av && !m_infl[src];
`endif
         chk("a_valid", tl_o.a_valid, exp_av);
         chk("d_ready", tl_o.d_ready, 1);
         chk("busy", busy_o, m_busy);
         chk("done", done_o, m_done);
         chk("rsp_cnt", rsp_cnt_o, m_rsp);
         chk("err_cnt", err_cnt_o, m_err);
         chk("last_rdata", last_rdata_o, m_rdata);
         if (prev_stall) begin
            chk("a_hold_valid", tl_o.a_valid, 1);
            chk("a_hold_fields", 32'(tl_o == prev_tl), 1);
         end
         if (exp_av) begin
            chk("a_address", tl_o.a_address, m_base + 32'(m_issued * STRIDE));
            chk("a_opcode", tl_o.a_opcode, m_write ? 3'd0 : 3'd4);
            chk("a_data", tl_o.a_data, m_write ? m_wdata : 32'h0);
            chk("a_source", tl_o.a_source, src);
            chk("a_size", tl_o.a_size, 2);
            chk("a_mask", tl_o.a_mask, 4'hf);
            chk("a_param", tl_o.a_param, 0);
            chk("a_user", 32'(tl_o.a_user == TL_A_USER_DEFAULT), 1);
         end
         // device side uses the DUT's real handshakes
         if (tl_o.a_valid && tl_i.a_ready) begin
            ahs_cnt++;
            log_addr.push_back(tl_o.a_address);
            log_src.push_back(tl_o.a_source);
            log_data.push_back(tl_o.a_data);
            log_op.push_back(tl_o.a_opcode);
            dev_q.push_back('{tl_o.a_source, tl_o.a_opcode == Get,
                              cyc + (dlat_rand ? 1 + int'($urandom % 4) : dlat)});
         end
         if (tl_o.a_valid) av_cyc++;
         if (tl_o.a_valid && !tl_i.a_ready) stall_cyc++;
         if (done_o) done_cnt++;
         dhs = tl_i.d_valid && tl_o.d_ready;
         if (dhs && d_from_q) begin
            void'(dev_q.pop_front());
            dev_rsp_idx++;
         end
         // model step
         ahs = exp_av && tl_i.a_ready;
         d_ok = dhs && (m_out > 0);
`ifdef TLUL_HOST_SEQ_SRC_CHECK_EN
         d_ok = d_ok && (tl_i.d_source < MAXO) && m_infl[tl_i.d_source[3:0]];
`endif
         if (dhs) begin
            m_rsp++;
            if ((tl_i.d_error || !d_ok) && (m_err != '1)) m_err++;
            if (tl_i.d_opcode == AccessAckData) m_rdata = tl_i.d_data;
         end
         if (m_done) begin
            m_done = 0;
         end else if (m_busy) begin
            drain = (m_issued == m_count);
            if (ahs) begin
               m_issued++; m_out++;
               m_infl[src] = 1'b1;
            end
            if (d_ok) begin
               m_out--;
               m_infl[tl_i.d_source[3:0]] = 1'b0;
            end
            if (drain && m_out == 0) begin
               m_busy = 0; m_done = 1;
            end
         end else if (start_i) begin
            if (count_i != '0) begin
               m_busy = 1; m_base = base_addr_i; m_count = int'(count_i);
               m_write = write_i; m_wdata = wdata_i; m_issued = 0; m_out = 0;
               m_rsp = '0; m_err = '0; m_rdata = '0; m_infl = '0;
            end else begin
               m_done = 1;
            end
         end
         prev_stall = tl_o.a_valid && !tl_i.a_ready;
         prev_tl = tl_o;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      start_i = 1'b0;
      if (start_req) begin
         start_i = 1'b1; base_addr_i = req_base; count_i = req_count;
         write_i = req_write; wdata_i = req_wdata; start_req = 0;
      end else if (noise && (m_busy || m_done)) begin
         start_i = ($urandom % 4 == 0); base_addr_i = $urandom;
         count_i = CW'($urandom % 5); write_i = $urandom % 2; wdata_i = $urandom;
      end
      tl_i = '0;
      tl_i.d_data = $urandom;
      d_from_q = 0;
      case (ar_mode)
         0: tl_i.a_ready = 1'b1;
         1: tl_i.a_ready = $urandom % 2;
         2: begin
            tl_i.a_ready = !(ar_low > 0 && tl_o.a_valid);
            if (ar_low > 0 && tl_o.a_valid) ar_low--;
         end
         default: tl_i.a_ready = (ahs_cnt < ar_budget);
      endcase
      if (inj_req) begin
         tl_i.d_valid = 1'b1; tl_i.d_source = inj_src; tl_i.d_opcode = AccessAck;
         inj_req = 0;
      end else if (dev_q.size() > 0 && cyc >= dev_q[0].rdy && cyc >= d_hold_until
                   && (!dgap_rand || ($urandom % 3 != 0))) begin
         tl_i.d_valid  = 1'b1;
         tl_i.d_source = dev_q[0].src;
         tl_i.d_opcode = dev_q[0].get ? AccessAckData : AccessAck;
         tl_i.d_error  = err_rand ? ($urandom % 6 == 0) : (dev_rsp_idx == err_at);
         d_from_q = 1;
      end
   endtask

   task automatic start_seq(logic [31:0] b, int n, bit w, logic [31:0] wd);
      req_base = b; req_count = CW'(n); req_write = w; req_wdata = wd; start_req = 1;
      step();
   endtask

   task automatic wait_done(int d0, int budget, string tag);
      int k = 0;
      while (done_cnt == d0 && k < budget) begin
         step();
         k++;
      end
      step();
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      logic [31:0] t1_addr[3];
      int d0, a0, k;
      t1_addr = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008};

      repeat (3) step();
      chk("rst_busy_lit", busy_o, 0);
      chk("rst_d_ready_lit", tl_o.d_ready, 1);
      rst_i = 1'b0;
      step();

      // Three writes, 1-cycle ack
      log_addr.delete(); log_src.delete(); log_data.delete(); log_op.delete();
      d0 = done_cnt;
      start_seq(32'h4000_0000, 3, 1, 32'hA5A5_A5A5);
      wait_done(d0, 50, "t1");
      chk("t1_nreq", log_addr.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("t1_addr", log_addr[i], t1_addr[i]);
         chk("t1_src", log_src[i], i);
         chk("t1_data", log_data[i], 32'hA5A5_A5A5);
         chk("t1_op", log_op[i], 0);
      end
      chk("t1_rsp", rsp_cnt_o, 3);
      chk("t1_err", err_cnt_o, 0);
      chk("t1_rdata", last_rdata_o, 0);

      // Eight reads, responses withheld
      a0 = ahs_cnt; d0 = done_cnt;
      d_hold_until = cyc + 25;
      start_seq(32'h0000_2000, 8, 0, 32'h0);
      repeat (20) step();
      chk("t2_ahs_during_hold", ahs_cnt - a0, 4);
      chk("t2_a_valid_blocked", tl_o.a_valid, 0);
      wait_done(d0, 200, "t2");
      chk("t2_ahs_total", ahs_cnt - a0, 8);
      chk("t2_rsp", rsp_cnt_o, 8);
      d_hold_until = 0;

      // a_ready low for 5 cycles on the first request
      log_addr.delete();
      ar_mode = 2; ar_low = 5; k = stall_cyc; d0 = done_cnt;
      start_seq(32'h0000_1000, 2, 1, 32'h1234_5678);
      wait_done(d0, 60, "t3");
      chk("t3_stall_cycles", stall_cyc - k, 5);
      chk("t3_addr0", log_addr[0], 32'h0000_1000);
      chk("t3_addr1", log_addr[1], 32'h0000_1004);
      ar_mode = 0;

      // Second response errored
      err_at = dev_rsp_idx + 1; d0 = done_cnt;
      start_seq(32'h0000_3000, 2, 0, 32'h0);
      wait_done(d0, 50, "t4");
      chk("t4_err", err_cnt_o, 1);
      chk("t4_rsp", rsp_cnt_o, 2);
      err_at = -1;

      // Address wrap and zero-length sequence
      log_addr.delete(); d0 = done_cnt;
      start_seq(32'hFFFF_FFFC, 2, 1, 32'hDEAD_BEEF);
      wait_done(d0, 50, "t5");
      chk("t5_addr0", log_addr[0], 32'hFFFF_FFFC);
      chk("t5_addr1_wrap", log_addr[1], 32'h0000_0000);
      a0 = av_cyc;
      start_seq(32'h0000_5000, 0, 0, 32'h0);
      step();
      chk("t5_zero_done", done_o, 1);
      step();
      chk("t5_zero_done_once", done_o, 0);
      chk("t5_zero_idle", busy_o, 0);
      chk("t5_zero_no_a_valid", av_cyc - a0, 0);
      chk("t5_cnt_hold", rsp_cnt_o, 2);

      // Reset with two requests outstanding, then a late response
      ar_mode = 3; ar_budget = ahs_cnt + 2; d_hold_until = cyc + 1000;
      start_seq(32'h0000_6000, 4, 0, 32'h0);
      k = 0;
      while (ahs_cnt < ar_budget && k < 20) begin
         step();
         k++;
      end
      chk("t6_two_issued", ahs_cnt, ar_budget);
      chk("t6_a_valid_pre", tl_o.a_valid, 1);
      rst_i = 1'b1;
      #1;
      chk("t6_a_valid_rst", tl_o.a_valid, 0);
      chk("t6_busy_rst", busy_o, 0);
      step(); step();
      rst_i = 1'b0;
      d_hold_until = 0; ar_mode = 0;
      step();
      inj_src = 8'd0; inj_req = 1;
      step(); step();
      chk("t6_late_err", err_cnt_o, 1);
      chk("t6_late_rsp", rsp_cnt_o, 1);
      chk("t6_idle", busy_o, 0);

`ifdef TLUL_HOST_SEQ_SRC_CHECK_EN
      // Response with a source that was never issued
      d0 = done_cnt; d_hold_until = cyc + 8;
      start_seq(32'h0000_7000, 2, 0, 32'h0);
      step(); step();
      inj_src = 8'd7; inj_req = 1;
      step(); step();
      chk("t7_bad_src_err", err_cnt_o, 1);
      chk("t7_still_busy", busy_o, 1);
      wait_done(d0, 60, "t7");
      chk("t7_rsp", rsp_cnt_o, 3);
      chk("t7_err_final", err_cnt_o, 1);
      d_hold_until = 0;
`endif

      // Randomized sequences with backpressure, latency, errors and ignored starts
      dlat_rand = 1; dgap_rand = 1; err_rand = 1; noise = 1;
      for (int s = 0; s < 40; s++) begin
         ar_mode = $urandom % 2;
         d0 = done_cnt;
         start_seq($urandom, 1 + int'($urandom % 12), $urandom % 2, $urandom);
         wait_done(d0, 400, "rand");
      end
      noise = 0; err_rand = 0; dgap_rand = 0; dlat_rand = 0; ar_mode = 0;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
